// File: rtl/lsu_ctrl.sv
// Load/store unit sequencing one execute-stage access at a time onto the data bus.
// Optional DATA-phase abort counter is enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_req,
  input  logic        ls_store,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_busy,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        ls_misalign,
  output logic        data_req,
  output logic        data_w_rb,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wd,
  input  logic [31:0] data_rd,
  input  logic        data_done,
  input  logic        data_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_FAIL
  } state_t;

  state_t      r_state;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        r_failMis;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_misalign;
  logic        r_dataReq;
  logic        r_wRb;
  logic [1:0]  r_size;
  logic [31:0] r_dataAddr;
  logic [31:0] r_dataWd;

  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_storeData;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadResult;
  logic        w_timeout;

  // Request decode: stores only have B/H/W encodings.
  always_comb begin
    w_illegal = 1'b0;
    if (ls_store) begin
      w_illegal = ls_funct3[2] | (ls_funct3[1:0] == 2'b11);
    end else begin
      w_illegal = (ls_funct3 == 3'b011) | (ls_funct3 == 3'b110) | (ls_funct3 == 3'b111);
    end
    case (ls_funct3[1:0])
      2'b01:   w_misalign = ls_addr[0];
      2'b10:   w_misalign = |ls_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
    case (ls_funct3[1:0])
      2'b00:   w_storeData = {4{ls_wdata[7:0]}};
      2'b01:   w_storeData = {2{ls_wdata[15:0]}};
      default: w_storeData = ls_wdata;
    endcase
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = data_rd[7:0];
      2'd1:    w_byte = data_rd[15:8];
      2'd2:    w_byte = data_rd[23:16];
      default: w_byte = data_rd[31:24];
    endcase
    w_half = r_lane[1] ? data_rd[31:16] : data_rd[15:0];
    case (r_funct3)
      3'b000:  w_loadResult = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_loadResult = {24'd0, w_byte};
      3'b001:  w_loadResult = {{16{w_half[15]}}, w_half};
      3'b101:  w_loadResult = {16'd0, w_half};
      default: w_loadResult = data_rd;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_ADDR) begin
      r_cnt <= '0;
    end else if (r_state == S_DATA) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A data_done arriving on the limit cycle still completes normally.
  assign w_timeout = (r_state == S_DATA) && !data_done &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_store    <= 1'b0;
      r_funct3   <= 3'd0;
      r_lane     <= 2'd0;
      r_wdata    <= 32'd0;
      r_failMis  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      r_dataReq  <= 1'b0;
      r_wRb      <= 1'b0;
      r_size     <= 2'd0;
      r_dataAddr <= 32'd0;
      r_dataWd   <= 32'd0;
    end else begin
      r_done     <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      r_dataReq  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ls_req) begin
            r_store  <= ls_store;
            r_funct3 <= ls_funct3;
            r_lane   <= ls_addr[1:0];
            r_wdata  <= w_storeData;
            r_busy   <= 1'b1;
            if (w_illegal || w_misalign) begin
              r_state   <= S_FAIL;
              r_failMis <= !w_illegal;
            end else begin
              r_state    <= S_ADDR;
              r_dataReq  <= 1'b1;
              r_wRb      <= ls_store;
              r_size     <= ls_funct3[1:0];
              r_dataAddr <= ls_addr;
            end
          end
        end
        S_ADDR: begin
          r_state  <= S_DATA;
          r_dataWd <= r_store ? r_wdata : 32'd0;
        end
        S_DATA: begin
          if (data_done || w_timeout) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= data_done ? data_err : 1'b1;
            r_rdata    <= (data_done && !data_err && !r_store) ? w_loadResult : 32'd0;
            r_wRb      <= 1'b0;
            r_size     <= 2'd0;
            r_dataAddr <= 32'd0;
            r_dataWd   <= 32'd0;
          end
        end
        S_FAIL: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_err      <= !r_failMis;
          r_misalign <= r_failMis;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ls_busy     = r_busy;
  assign ls_done     = r_done;
  assign ls_rdata    = r_rdata;
  assign ls_err      = r_err;
  assign ls_misalign = r_misalign;
  assign data_req    = r_dataReq;
  assign data_w_rb   = r_wRb;
  assign data_size   = r_size;
  assign data_addr   = r_dataAddr;
  assign data_wd     = r_dataWd;

endmodule
